// File: rtl/interpolation_ram_ctrl.sv
// rtl/interpolation_ram_ctrl.sv - ping-pong bank sequencer feeding (x[k-1], x[k]) pairs to an interpolator
// Writer fills one RAM bank while the reader drains the other through a 2-entry pair FIFO.
module interpolation_ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_prev,
  output logic [DATA_WIDTH-1:0] m_cur,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            bank_full,
  output logic                  frame_done
);

  localparam int IW = ADDR_WIDTH - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  logic                  r_wr_bank;
  logic [IW-1:0]         r_wr_cnt;
  logic                  r_rd_bank;
  logic [IW-1:0]         r_rd_cnt;
  logic [1:0]            r_bank_full;
  logic                  r_inflight;
  logic [IW-1:0]         r_rd_idx;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_fifo_prev [2];
  logic [DATA_WIDTH-1:0] r_fifo_cur  [2];
  logic [1:0]            r_fifo_last;
  logic                  r_head;
  logic [1:0]            r_count;

  logic       w_accept;
  logic       w_wr_last;
  logic       w_pop;
  logic [2:0] w_occupancy;
  logic       w_issue;
  logic       w_rd_last;
  logic       w_push;
  logic       w_tail;
  logic [1:0] w_full_next;

  assign s_ready     = !rst && !r_bank_full[r_wr_bank];
  assign w_accept    = s_valid && s_ready;
  assign w_wr_last   = w_accept && (r_wr_cnt == LAST_IDX);
  assign ram_wr_en   = w_accept;
  assign ram_wr_addr = {r_wr_bank, r_wr_cnt};
  assign ram_wr_data = s_data;

  // Occupancy counts the read already in flight so the FIFO can never overflow.
  assign w_pop       = m_valid && m_ready;
  assign w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue     = r_bank_full[r_rd_bank] && (w_occupancy < 3'd2);
  assign w_rd_last   = w_issue && (r_rd_cnt == LAST_IDX);
  assign ram_rd_addr = {r_rd_bank, r_rd_cnt};

  assign w_push      = r_inflight && (r_rd_idx != '0);
  assign w_tail      = r_head ^ r_count[0];

  assign m_valid    = (r_count != 2'd0);
  assign m_prev     = r_fifo_prev[r_head];
  assign m_cur      = r_fifo_cur[r_head];
  assign m_last     = r_fifo_last[r_head];
  assign frame_done = w_pop && m_last;
  assign bank_full  = r_bank_full;

  // Set and clear always land on different banks, so both are applied.
  always_comb begin
    w_full_next = r_bank_full;
    if (w_wr_last) w_full_next[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_next[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank      <= 1'b0;
      r_wr_cnt       <= '0;
      r_rd_bank      <= 1'b0;
      r_rd_cnt       <= '0;
      r_bank_full    <= 2'b00;
      r_inflight     <= 1'b0;
      r_rd_idx       <= '0;
      r_prev         <= '0;
      r_fifo_prev[0] <= '0;
      r_fifo_prev[1] <= '0;
      r_fifo_cur[0]  <= '0;
      r_fifo_cur[1]  <= '0;
      r_fifo_last    <= 2'b00;
      r_head         <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_accept) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      r_bank_full <= w_full_next;
      r_inflight  <= w_issue;
      if (w_issue) begin
        r_rd_idx <= r_rd_cnt;
        if (w_rd_last) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
      // Index 0 only primes prev, which keeps pairs from spanning frames.
      if (r_inflight) r_prev <= ram_rd_data;
      if (w_push) begin
        r_fifo_prev[w_tail] <= r_prev;
        r_fifo_cur[w_tail]  <= ram_rd_data;
        r_fifo_last[w_tail] <= (r_rd_idx == LAST_IDX);
      end
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_interpolation_ram_ctrl.sv
// tb/tb_interpolation_ram_ctrl.sv - scoreboard bench for interpolation_ram_ctrl
// Driver pushes expected pairs as samples are accepted; monitors pop and compare.
module tb_interpolation_ram_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FL = 512;

  typedef struct packed {
    logic [DW-1:0] p;
    logic [DW-1:0] c;
    logic          l;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] m_prev, m_cur;
  logic          m_last, m_valid;
  logic          m_ready = 1'b1;
  logic [1:0]    bank_full;
  logic          frame_done;

  logic [DW-1:0] s2_data = '0;
  logic          s2_valid = 1'b0;
  logic          s2_ready;
  logic          wr2_en;
  logic [AW-1:0] wr2_addr;
  logic [DW-1:0] wr2_data;
  logic [AW-1:0] rd2_addr;
  logic [DW-1:0] rd2_data;
  logic [DW-1:0] m2_prev, m2_cur;
  logic          m2_last, m2_valid;
  logic          m2_ready = 1'b1;
  logic [1:0]    bank2_full;
  logic          frame2_done;

  interpolation_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_prev(m_prev), .m_cur(m_cur), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .bank_full(bank_full), .frame_done(frame_done)
  );

  interpolation_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .s_data(s2_data), .s_valid(s2_valid), .s_ready(s2_ready),
    .ram_wr_en(wr2_en), .ram_wr_addr(wr2_addr), .ram_wr_data(wr2_data),
    .ram_rd_addr(rd2_addr), .ram_rd_data(rd2_data),
    .m_prev(m2_prev), .m_cur(m2_cur), .m_last(m2_last), .m_valid(m2_valid), .m_ready(m2_ready),
    .bank_full(bank2_full), .frame_done(frame2_done)
  );

  logic [DW-1:0] mem  [1024];
  logic [DW-1:0] mem2 [1024];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
    if (wr2_en) mem2[wr2_addr] <= wr2_data;
    rd2_data <= mem2[rd2_addr];
  end

  int    n_checks = 0;
  int    n_pass = 0;
  pair_t q[$];
  pair_t q2[$];
  int    n_wr = 0;
  int    n_stall = 0;
  logic [DW-1:0] last_x = '0;
  logic  rand_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Main-DUT monitor: pair order, frame_done, and hold-during-stall.
  pair_t held;
  logic  held_v = 1'b0;
  always @(negedge clk) begin
    pair_t cur, exp;
    cur = {m_prev, m_cur, m_last};
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", {127'd0, m_valid}, 128'd1);
        check("hold_data", {63'd0, cur}, {63'd0, held});
      end
      held_v = 1'b0;
      if (m_valid && !m_ready) begin
        held = cur;
        held_v = 1'b1;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pair: got %h expected none", cur);
        end else begin
          exp = q.pop_front();
          check("pair", {63'd0, cur}, {63'd0, exp});
          check("frame_done", {127'd0, frame_done}, {127'd0, exp.l});
        end
      end
    end
  end

  always @(negedge clk) begin
    pair_t cur, exp;
    cur = {m2_prev, m2_cur, m2_last};
    if (!rst && m2_valid && m2_ready) begin
      if (q2.size() == 0) begin
        n_checks++;
        $display("FAIL fl2_unexpected_pair: got %h expected none", cur);
      end else begin
        exp = q2.pop_front();
        check("fl2_pair", {63'd0, cur}, {63'd0, exp});
        check("fl2_frame_done", {127'd0, frame2_done}, 128'd1);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_en) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst_s_ready", {127'd0, s_ready}, 128'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    n_wr = 0;
    @(negedge clk);
    check("rst_flags", {123'd0, m_valid, bank_full, s_ready, frame_done}, {123'd0, 5'b00010});
    check("rst_outputs", {m_prev, m_cur, 22'd0, ram_rd_addr, 2'd0, ram_wr_en, m_last},
          {64'd0, 64'd0});
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    int t = 0;
    s_data = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 5000) begin
      @(negedge clk);
      t++;
      n_stall++;
    end
    if (!s_ready) begin
      n_checks++;
      $display("FAIL put_timeout: got s_ready=0 expected 1 for sample %0h", d);
    end else begin
      check("wr_port", {85'd0, ram_wr_en, ram_wr_addr, ram_wr_data},
            {85'd0, 1'b1, AW'(n_wr % 1024), d});
      if ((n_wr % FL) != 0) q.push_back({last_x, d, (n_wr % FL) == FL - 1});
      last_x = d;
      n_wr++;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((q.size() != 0 || m_valid) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check(name, {96'd0, 32'(q.size())}, 128'd0);
    @(negedge clk);
    check({name, "_bank_full"}, {126'd0, bank_full}, 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [AW-1:0] prev_rd;
    logic [AW-1:0] exp_a2 [4];
    logic found;

    do_reset(3);

    // Single frame, latency from last accept to first pair.
    m_ready = 1'b1;
    for (int i = 0; i < FL; i++) put(DW'(i));
    @(negedge clk);
    check("t1_bank_full", {126'd0, bank_full}, 128'd1);
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", {96'd0, 32'(lat)}, 128'd4);
    drain("t1_drain");

    // Two frames back to back with no input stall.
    n_stall = 0;
    for (int i = 0; i < 2 * FL; i++) put(32'h1000_0000 + DW'(i));
    check("t2_no_stall", {96'd0, 32'(n_stall)}, 128'd0);
    drain("t2_drain");

    // Both banks fill under backpressure, then release.
    do_reset(1);
    m_ready = 1'b0;
    for (int i = 0; i < 2 * FL; i++) put(32'h2000_0000 + DW'(i));
    repeat (20) @(negedge clk);
    check("t3_blocked", {125'd0, s_ready, bank_full}, {125'd0, 3'b011});
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    prev_rd = ram_rd_addr;
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      @(negedge clk);
      if (s_ready) begin
        found = 1'b1;
        check("t3_ready_after_last_issue", {108'd0, prev_rd, ram_rd_addr},
              {108'd0, 10'd511, 10'd512});
      end else begin
        prev_rd = ram_rd_addr;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL t3_ready_return: got s_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    for (int i = 2 * FL; i < 3 * FL; i++) put(32'h2000_0000 + DW'(i));
    drain("t3_drain");

    // Random downstream stalls over two frames.
    rand_en = 1'b1;
    for (int i = 0; i < 2 * FL; i++) put(32'h5A00_0000 + DW'(i));
    drain("t4_drain");
    rand_en = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;

    // Reset in the middle of reading frame 0.
    do_reset(1);
    for (int i = 0; i < FL; i++) put(32'hC000_0000 + DW'(i));
    repeat (50) @(posedge clk);
    #1;
    do_reset(1);
    for (int i = 100; i < 100 + FL; i++) put(DW'(i));
    drain("t5_drain");

    // FRAME_LEN = 2 instance: one pair per frame, alternating banks.
    exp_a2[0] = 10'd0;
    exp_a2[1] = 10'd1;
    exp_a2[2] = 10'd512;
    exp_a2[3] = 10'd513;
    q2.push_back({32'd7, 32'd8, 1'b1});
    q2.push_back({32'd9, 32'd10, 1'b1});
    for (int i = 0; i < 4; i++) begin
      s2_data = 32'(7 + i);
      s2_valid = 1'b1;
      @(negedge clk);
      check("fl2_wr", {117'd0, s2_ready, wr2_en, wr2_addr}, {117'd0, 2'b11, exp_a2[i]});
      @(posedge clk);
      #1;
    end
    s2_valid = 1'b0;
    for (int t = 0; t < 30 && q2.size() != 0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("fl2_drain", {96'd0, 32'(q2.size())}, 128'd0);
    check("fl2_bank_full", {126'd0, bank2_full}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interpolation_ram_ctrl.md
Name: interpolation_ram_ctrl

Overview:
- Ping-pong sequencer for the 1024x32 simple-dual-port interpolation RAM (read latency 1, no output register).
- Splits the RAM into two banks of FRAME_LEN samples each.
- Fills one bank from an input valid/ready stream while the other bank is read out in order.
- Emits consecutive-sample pairs (x[k-1], x[k]) to the downstream linear interpolator, with full backpressure support.

Parameters:
ADDR_WIDTH, 10, RAM address width; bank select is MSB, so bank depth is 2^(ADDR_WIDTH-1).
DATA_WIDTH, 32, sample width; equals RAM data width.
FRAME_LEN, 512, samples per frame; legal range 2 .. 2^(ADDR_WIDTH-1).

Ports:
clk  in  1  single clock for the block and both RAM ports.
rst  in  1  synchronous, active-high reset.
s_data  in  DATA_WIDTH  input sample.
s_valid  in  1  input sample valid.
s_ready  out  1  block can accept a sample.
ram_wr_en  out  1  RAM write enable.
ram_wr_addr  out  ADDR_WIDTH  RAM write address.
ram_wr_data  out  DATA_WIDTH  RAM write data.
ram_rd_addr  out  ADDR_WIDTH  RAM read address; the RAM samples it every clock.
ram_rd_data  in  DATA_WIDTH  RAM read data, valid one cycle after the address.
m_prev  out  DATA_WIDTH  sample x[k-1].
m_cur  out  DATA_WIDTH  sample x[k].
m_last  out  1  marks the pair with k = FRAME_LEN-1.
m_valid  out  1  output pair valid.
m_ready  in  1  downstream accepts the pair.
bank_full  out  2  per-bank "frame written, not yet fully read" flags.
frame_done  out  1  one-cycle pulse on the m_last handshake.

Behaviour:
Reset (sync, rst=1):
- wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0, bank_full=00, output FIFO empty, in-flight flag=0.
- Outputs: m_valid=0, m_last=0, frame_done=0, ram_wr_en=0, ram_rd_addr=0, m_prev/m_cur=0.
- s_ready is forced 0 while rst=1; it is 1 on the first cycle after reset.
- Reset mid-frame discards all partial state; RAM contents are ignored.

Write side:
- s_ready = !bank_full[wr_bank].
- Accept = s_valid & s_ready. On accept: ram_wr_en=1, ram_wr_addr={wr_bank, wr_cnt}, ram_wr_data=s_data. All three are combinational from the handshake.
- Accept with wr_cnt = FRAME_LEN-1: bank_full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0. Otherwise wr_cnt increments.
- Writes never target a full bank, so there is no overflow.

Read side:
- ram_rd_addr={rd_bank, rd_cnt}.
- A read is issued in a cycle when bank_full[rd_bank]=1 and (fifo_count - pop + inflight) < 2. Here pop = m_valid & m_ready this cycle.
- On issue: inflight<=1 and the issued index is registered; otherwise inflight<=0.
- Issue with rd_cnt = FRAME_LEN-1: bank_full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
- The writer may reuse that bank from the next cycle. Its read has already been sampled, so there is no hazard.
- Set and clear of bank_full in the same cycle always hit different banks; both take effect.
- Data return (inflight=1), using ram_rd_data:
  - Index 0: prev<=data; no push.
  - Index k>0: push {prev, data, k==FRAME_LEN-1} into the 2-entry output FIFO; prev<=data.
- Output FIFO: 2 entries, registered. m_valid = FIFO not empty. Pop on m_valid & m_ready. Push and pop in the same cycle are allowed.

Latency and throughput:
- Last write of a frame accepted in cycle C -> index-0 read issued in C+1 -> index-1 read in C+2 -> first pair pushed at the end of C+3 -> m_valid=1 in C+4.
- With m_ready held high, one pair per cycle. Each frame yields FRAME_LEN-1 pairs.
- Consecutive full banks stream back-to-back. Pairs never span frames, because the prev register is reloaded at index 0.

Backpressure:
- m_ready=0 stalls issue once the FIFO plus the in-flight read reaches 2.
- m_prev, m_cur and m_last hold stable while m_valid=1 and m_ready=0.

Test Plan:
- Reset then write 512 samples 0..511 with s_valid=1 and m_ready=1 -> ram_wr_addr 0..511, bank_full=01. First m_valid 4 cycles after the last accept. 511 pairs (k-1,k), k=1..511, one per cycle. m_last and frame_done on (510,511). bank_full returns to 00.
- Write 1024 samples continuously -> second frame goes to addresses 512..1023 with s_ready staying 1. Reads of bank 0 overlap the bank-1 writes. Output is 1022 pairs with no cross-frame pair (511,512).
- Write 1536 samples with m_ready=0 -> s_ready drops after sample 1023 (both banks full). Raising m_ready drains pairs in order, and s_ready returns 1 the cycle after bank 0's final read issue.
- Toggle m_ready randomly 50% over 2 frames -> every pair is delivered exactly once, in order, with held data stable during stalls. The FIFO never exceeds 2 entries.
- Assert rst for 1 cycle mid-read of frame 0 -> next cycle m_valid=0, bank_full=00, s_ready=1. A new frame 100..611 yields pairs starting at (100,101) from address 0.
- FRAME_LEN=2 -> each frame yields exactly one pair with m_last=1. Bank addresses alternate 0,1 / 512,513.
